// File: rtl/ex_mem_pkg.sv
// Shared EX/MEM definitions: enable levels, NOP encodings, default widths and
// the per-cycle stage action decode used by the pipeline register.
package ex_mem_pkg;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_ALUOP_W    = 8;
    localparam int DEF_CNT_W      = 2;
    localparam int DEF_HOLD_W     = 8;

    localparam int ZERO_WORD     = 0;
    localparam int NOP_REG_ADDR  = 0;
    localparam int ALUOP_NOP     = 0;

    typedef enum logic [1:0] {
        ACT_CLEAR   = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_HOLD    = 2'd2,
        ACT_ADVANCE = 2'd3
    } stage_act_e;

    // stall_mem without stall_ex cannot come from a sane controller; it falls
    // through to advance because only stall_ex gates forward progress.
    function automatic stage_act_e decode_act(input logic rst, input logic flush,
                                              input logic stall_ex, input logic stall_mem);
        if (rst == RST_ENABLE || flush) return ACT_CLEAR;
        if (!stall_ex)                  return ACT_ADVANCE;
        if (stall_mem)                  return ACT_HOLD;
        return ACT_BUBBLE;
    endfunction

endpackage

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with stall-hold, bubble insertion, flush, a valid
// bit and a feedback path returning partial multi-cycle results to EX.
module ex_mem_pipe
    import ex_mem_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int ALUOP_W    = DEF_ALUOP_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int HOLD_W     = DEF_HOLD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall_ex,
    input  logic                  stall_mem,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic                  ex_whilo,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [DATA_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_reg2,
    input  logic [2*DATA_W-1:0]   ex_hilo_temp,
    input  logic [CNT_W-1:0]      ex_cnt,
    output logic                  mem_valid,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_whilo,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic [ALUOP_W-1:0]    mem_aluop,
    output logic [DATA_W-1:0]     mem_mem_addr,
    output logic [DATA_W-1:0]     mem_reg2,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [CNT_W-1:0]      cnt_o,
    output logic [HOLD_W-1:0]     hold_cnt
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [DATA_W-1:0]     wdata;
        logic                  whilo;
        logic [DATA_W-1:0]     hi;
        logic [DATA_W-1:0]     lo;
        logic [ALUOP_W-1:0]    aluop;
        logic [DATA_W-1:0]     mem_addr;
        logic [DATA_W-1:0]     reg2;
    } mem_fields_t;

    localparam mem_fields_t MEM_NOP = '{
        valid:    1'b0,
        wd:       REG_ADDR_W'(NOP_REG_ADDR),
        wreg:     WRITE_DISABLE,
        wdata:    DATA_W'(ZERO_WORD),
        whilo:    WRITE_DISABLE,
        hi:       DATA_W'(ZERO_WORD),
        lo:       DATA_W'(ZERO_WORD),
        aluop:    ALUOP_W'(ALUOP_NOP),
        mem_addr: DATA_W'(ZERO_WORD),
        reg2:     DATA_W'(ZERO_WORD)
    };

    mem_fields_t   mem_q;
    mem_fields_t   ex_fields;
    stage_act_e    act;

    assign ex_fields = '{
        valid:    ex_valid,
        wd:       ex_wd,
        wreg:     ex_wreg,
        wdata:    ex_wdata,
        whilo:    ex_whilo,
        hi:       ex_hi,
        lo:       ex_lo,
        aluop:    ex_aluop,
        mem_addr: ex_mem_addr,
        reg2:     ex_reg2
    };

    assign act = decode_act(rst, flush, stall_ex, stall_mem);

    // NOTE: state updates use non-blocking assignments so every register samples
    // pre-edge values; reset is synchronous, so it is just the highest-priority case.
    always_ff @(posedge clk) begin
        unique case (act)
            ACT_CLEAR: begin
                mem_q    <= MEM_NOP;
                hilo_o   <= '0;
                cnt_o    <= '0;
                hold_cnt <= '0;
            end
            ACT_BUBBLE: begin
                mem_q    <= MEM_NOP;
                hilo_o   <= ex_hilo_temp;
                cnt_o    <= ex_cnt;
                hold_cnt <= '0;
            end
            ACT_HOLD: begin
                if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
            end
            ACT_ADVANCE: begin
                mem_q    <= ex_fields;
                hilo_o   <= '0;
                cnt_o    <= '0;
                hold_cnt <= '0;
            end
            default: begin
                mem_q    <= MEM_NOP;
                hilo_o   <= '0;
                cnt_o    <= '0;
                hold_cnt <= '0;
            end
        endcase
    end

    assign mem_valid    = mem_q.valid;
    assign mem_wd       = mem_q.wd;
    assign mem_wreg     = mem_q.wreg;
    assign mem_wdata    = mem_q.wdata;
    assign mem_whilo    = mem_q.whilo;
    assign mem_hi       = mem_q.hi;
    assign mem_lo       = mem_q.lo;
    assign mem_aluop    = mem_q.aluop;
    assign mem_mem_addr = mem_q.mem_addr;
    assign mem_reg2     = mem_q.reg2;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: default-width instance plus a 64-bit data /
// 6-bit register-address instance sharing clock, reset and stall controls.
module tb_ex_mem_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush, stall_ex, stall_mem, ex_valid;

    // Default-width instance signals
    logic [4:0]  ex_wd;
    logic        ex_wreg, ex_whilo;
    logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
    logic [7:0]  ex_aluop;
    logic [63:0] ex_hilo_temp;
    logic [1:0]  ex_cnt;
    logic        mem_valid, mem_wreg, mem_whilo;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
    logic [7:0]  mem_aluop;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;
    logic [7:0]  hold_cnt;

    // Wide instance signals
    logic [5:0]   w_ex_wd, w_mem_wd;
    logic         w_mem_valid, w_mem_wreg, w_mem_whilo;
    logic [63:0]  w_ex_hi, w_mem_hi, w_mem_wdata, w_mem_lo, w_mem_mem_addr, w_mem_reg2;
    logic [7:0]   w_mem_aluop;
    logic [127:0] w_hilo_o;
    logic [1:0]   w_cnt_o;
    logic [7:0]   w_hold_cnt;

    ex_mem_pipe dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop),
        .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .ex_hilo_temp(ex_hilo_temp),
        .ex_cnt(ex_cnt),
        .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop),
        .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o),
        .hold_cnt(hold_cnt)
    );

    ex_mem_pipe #(.DATA_W(64), .REG_ADDR_W(6)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .ex_valid(ex_valid), .ex_wd(w_ex_wd), .ex_wreg(1'b1), .ex_wdata(64'h0),
        .ex_whilo(1'b1), .ex_hi(w_ex_hi), .ex_lo(64'h0), .ex_aluop(8'h0),
        .ex_mem_addr(64'h0), .ex_reg2(64'h0), .ex_hilo_temp(128'h0), .ex_cnt(2'd0),
        .mem_valid(w_mem_valid), .mem_wd(w_mem_wd), .mem_wreg(w_mem_wreg),
        .mem_wdata(w_mem_wdata), .mem_whilo(w_mem_whilo), .mem_hi(w_mem_hi),
        .mem_lo(w_mem_lo), .mem_aluop(w_mem_aluop), .mem_mem_addr(w_mem_mem_addr),
        .mem_reg2(w_mem_reg2), .hilo_o(w_hilo_o), .cnt_o(w_cnt_o), .hold_cnt(w_hold_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] observed,
                         input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and land 1 time unit past the edge for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [4:0] wd, input logic [31:0] wdata, input logic wreg);
        ex_valid    = 1'b1;
        ex_wd       = wd;
        ex_wreg     = wreg;
        ex_wdata    = wdata;
        ex_whilo    = 1'b1;
        ex_hi       = wdata ^ 32'hFFFF_0000;
        ex_lo       = wdata ^ 32'h0000_FFFF;
        ex_aluop    = 8'hA3;
        ex_mem_addr = wdata + 32'h100;
        ex_reg2     = ~wdata;
    endtask

    initial begin
        flush = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0;
        set_ex(5'd17, 32'hCAFE_F00D, 1'b1);
        ex_hilo_temp = 64'h1111_2222_3333_4444;
        ex_cnt = 2'd3;
        w_ex_wd = 6'd9; w_ex_hi = 64'h1234;

        // Reset with nonzero inputs for two cycles
        rst = 1'b1;
        step(); step();
        check("rst_valid", mem_valid, 0);
        check("rst_wd", mem_wd, 0);
        check("rst_wreg", mem_wreg, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_whilo", mem_whilo, 0);
        check("rst_aluop", mem_aluop, 0);
        check("rst_hilo", hilo_o, 0);
        check("rst_hold", hold_cnt, 0);
        rst = 1'b0;

        // Plain advance
        set_ex(5'd5, 32'hDEAD_BEEF, 1'b1);
        step();
        check("adv_wd", mem_wd, 5);
        check("adv_wreg", mem_wreg, 1);
        check("adv_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("adv_valid", mem_valid, 1);
        check("adv_hi", mem_hi, 32'h2152_BEEF);
        check("adv_lo", mem_lo, 32'hDEAD_4110);
        check("adv_addr", mem_mem_addr, 32'hDEAD_BFEF);
        check("adv_reg2", mem_reg2, 32'h2152_4110);
        check("adv_aluop", mem_aluop, 8'hA3);

        // Multi-cycle bubble: partial result captured, MEM sees a bubble
        stall_ex = 1'b1;
        ex_hilo_temp = 64'h0000_0001_0000_0002;
        ex_cnt = 2'd1;
        set_ex(5'd7, 32'h0000_0042, 1'b1);
        step();
        check("bub_valid", mem_valid, 0);
        check("bub_wreg", mem_wreg, 0);
        check("bub_whilo", mem_whilo, 0);
        check("bub_wd", mem_wd, 0);
        check("bub_hilo", hilo_o, 64'h0000_0001_0000_0002);
        check("bub_cnt", cnt_o, 1);
        stall_ex = 1'b0;
        step();
        check("rel_hilo", hilo_o, 0);
        check("rel_cnt", cnt_o, 0);
        check("rel_wd", mem_wd, 7);
        check("rel_wdata", mem_wdata, 32'h42);
        check("rel_valid", mem_valid, 1);

        // Hold: load 0x1234, then stall both for 300 cycles with changing inputs
        set_ex(5'd3, 32'h0000_1234, 1'b1);
        step();
        check("hold_load", mem_wdata, 32'h1234);
        stall_ex = 1'b1; stall_mem = 1'b1;
        for (int i = 0; i < 300; i++) begin
            set_ex(5'(i), 32'h5000_0000 + 32'(i), 1'b0);
            ex_hilo_temp = 64'(i) << 8;
            ex_cnt = 2'(i);
            step();
            if (i == 9)   check("hold_cnt10", hold_cnt, 10);
            if (i == 254) check("hold_cnt255", hold_cnt, 255);
        end
        check("hold_sat", hold_cnt, 255);
        check("hold_wdata", mem_wdata, 32'h1234);
        check("hold_wd", mem_wd, 3);
        check("hold_valid", mem_valid, 1);
        check("hold_hilo", hilo_o, 0);

        // Leaving hold via advance clears the counter
        stall_ex = 1'b0; stall_mem = 1'b0;
        set_ex(5'd12, 32'h0BAD_0BAD, 1'b1);
        step();
        check("unhold_cnt", hold_cnt, 0);
        check("unhold_wd", mem_wd, 12);

        // Flush beats hold: valid stage with hold_cnt>0
        stall_ex = 1'b1; stall_mem = 1'b1;
        step(); step(); step();
        check("pre_flush_hold", hold_cnt, 3);
        check("pre_flush_valid", mem_valid, 1);
        flush = 1'b1;
        step();
        check("fl_valid", mem_valid, 0);
        check("fl_wd", mem_wd, 0);
        check("fl_wdata", mem_wdata, 0);
        check("fl_hold", hold_cnt, 0);
        check("fl_hilo", hilo_o, 0);
        flush = 1'b0;

        // Flush mid multi-cycle op discards partial result
        stall_mem = 1'b0;
        ex_hilo_temp = 64'hABCD_0000_0000_1234;
        ex_cnt = 2'd2;
        step();
        check("bub2_hilo", hilo_o, 64'hABCD_0000_0000_1234);
        check("bub2_cnt", cnt_o, 2);
        flush = 1'b1;
        step();
        check("fl2_hilo", hilo_o, 0);
        check("fl2_cnt", cnt_o, 0);
        flush = 1'b0;

        // Illegal controller combination: behaves as advance
        stall_ex = 1'b0; stall_mem = 1'b1;
        $display("note: driving illegal stall_ex=0 stall_mem=1 combination");
        set_ex(5'd21, 32'h7777_8888, 1'b1);
        step();
        check("ill_wd", mem_wd, 21);
        check("ill_wdata", mem_wdata, 32'h7777_8888);
        check("ill_hold", hold_cnt, 0);
        stall_mem = 1'b0;

        // Wide instance: bit-exact at the top of each field
        w_ex_hi = 64'hFFFF_FFFF_FFFF_FFFF;
        w_ex_wd = 6'd63;
        step();
        check("w_hi", w_mem_hi, 64'hFFFF_FFFF_FFFF_FFFF);
        check("w_wd", w_mem_wd, 63);
        check("w_valid", w_mem_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
